// File: rtl/multi_unit.sv
// ----------------------------------------------------------------------------
// multi_unit
//   Sequential shift-add unsigned multiplier with a start/done handshake.
//   One partial product is accumulated per RUN cycle (WIDTH cycles). A FIN
//   cycle then registers the outputs, so done arrives WIDTH+2 cycles after
//   start is sampled.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           synchronous reset, active-high, highest priority
//   start         request, sampled only while idle (busy = 0)
//   a, b          unsigned operands, captured on accepted start
//   busy          high while the FSM is in RUN or FIN
//   done          one-cycle pulse; outputs below are valid from this cycle
//   result        product truncated to RES_W LSBs
//   product_full  full 2*WIDTH-bit product
//   overflow      product does not fit in RES_W bits
// ----------------------------------------------------------------------------
module multi_unit #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned RES_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [RES_W-1:0]     result,
   output logic [2*WIDTH-1:0]   product_full,
   output logic                 overflow
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFin
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [RES_W-1:0]  result_q, result_d;
   logic [PW-1:0]     product_q, product_d;
   logic              overflow_q, overflow_d;
   logic              acc_ovf;

   // Bits of the accumulator that do not fit in the truncated result.
   generate
      if (RES_W < PW) begin : g_ovf
         assign acc_ovf = |acc_q[PW-1:RES_W];
      end else begin : g_no_ovf
         assign acc_ovf = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      result_d   = result_q;
      product_d  = product_q;
      overflow_d = overflow_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d  = PW'(a);
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StFin;
            end
         end
         StFin: begin
            // Outputs are registered here, so done lands one cycle after FIN.
            product_d  = acc_q;
            result_d   = acc_q[RES_W-1:0];
            overflow_d = acc_ovf;
            done_d     = 1'b1;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         result_q   <= '0;
         product_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         result_q   <= result_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign done         = done_q;
   assign result       = result_q;
   assign product_full = product_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_multi_unit.sv
// ----------------------------------------------------------------------------
// tb_multi_unit
//   Directed self-checking bench for multi_unit at WIDTH=3, RES_W=4.
// ----------------------------------------------------------------------------
module tb_multi_unit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] a;
   logic [2:0] b;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic [5:0] product_full;
   logic       overflow;

   int compared;
   int mismatched;

   multi_unit #(
      .WIDTH (3),
      .RES_W (4)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .product_full (product_full),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start one operation, wait for done and check latency and outputs.
   task automatic run_op(input int av, input int bv, input string tag);
      int lat;
      int p;
      p     = av * bv;
      a     = 3'(av);
      b     = 3'(bv);
      start = 1'b1;
      step();
      start = 1'b0;
      a     = 3'($urandom);
      b     = 3'($urandom);
      check({tag, "_busy"}, int'(busy), 1);
      lat = 1;
      while (!done && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_latency"}, lat, 5);
      check({tag, "_product"}, int'(product_full), p);
      check({tag, "_result"}, int'(result), p % 16);
      check({tag, "_overflow"}, int'(overflow), (p > 15) ? 1 : 0);
      step();
      check({tag, "_done_pulse"}, int'(done), 0);
      check({tag, "_idle"}, int'(busy), 0);
   endtask

   initial begin
      int lat;
      int ndone;
      int av;
      int bv;
      compared   = 0;
      mismatched = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      check("rst_product", int'(product_full), 0);
      check("rst_overflow", int'(overflow), 0);

      // Basic operations and boundaries.
      run_op(7, 2, "t1");
      step();
      step();
      check("t1_hold", int'(result), 14);
      run_op(7, 7, "t2_ovf");
      run_op(3, 5, "t2_bound");
      run_op(0, 5, "t3_a0");
      run_op(5, 0, "t3_b0");

      // Start while busy must be ignored.
      a     = 3'd7;
      b     = 3'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      lat   = 1;
      step();
      lat++;
      step();
      lat++;
      a     = 3'd1;
      b     = 3'd1;
      start = 1'b1;
      step();
      lat++;
      start = 1'b0;
      a     = 3'd3;
      b     = 3'd3;
      while (!done && lat < 20) begin
         step();
         lat++;
      end
      check("t4_done", int'(done), 1);
      check("t4_latency", lat, 5);
      check("t4_result", int'(result), 14);
      check("t4_product", int'(product_full), 14);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) ndone++;
      end
      check("t4_single_done", ndone, 0);

      // Reset mid-operation aborts everything.
      a     = 3'd7;
      b     = 3'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_busy", int'(busy), 0);
      check("t5_done", int'(done), 0);
      check("t5_result", int'(result), 0);
      check("t5_product", int'(product_full), 0);
      check("t5_overflow", int'(overflow), 0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) ndone++;
      end
      check("t5_no_done", ndone, 0);
      run_op(2, 3, "t5_after");

      // Back-to-back random operands.
      for (int i = 0; i < 20; i++) begin
         av = int'($urandom_range(0, 7));
         bv = int'($urandom_range(0, 7));
         run_op(av, bv, $sformatf("t6_%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
